// File: rtl/ycbcr2rgb.sv
// Pipelined YCbCr-to-RGB converter: 8.8 fixed-point shift-add coefficients with
// round-half-up and saturation. A single advance enable stalls the whole pipe on backpressure.
module ycbcr2rgb #(
    parameter int INT_WIDTH = 8,
    parameter int FP_WIDTH  = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_WIDTH-1:0] Y,
    input  logic [INT_WIDTH-1:0] Cb,
    input  logic [INT_WIDTH-1:0] Cr,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [INT_WIDTH-1:0] R,
    output logic [INT_WIDTH-1:0] G,
    output logic [INT_WIDTH-1:0] B,
    output logic                 dout_valid,
    input  logic                 dout_ready
);

    localparam int FRAC = 8;
    localparam int MAGW = INT_WIDTH + FRAC;
    localparam int NSH  = 6;
    // Shift amounts actually used by the coefficients, per chroma component.
    localparam int CB_SH [NSH] = '{0, 1, 2, 4, 5, 6};
    localparam int CR_SH [NSH] = '{0, 1, 2, 3, 4, 5};

    typedef logic signed [FP_WIDTH-1:0] fp_t;

    function automatic logic [INT_WIDTH-1:0] sat_pixel(input fp_t s);
        if (s[FP_WIDTH-1])
            return '0;
        else if (|s[FP_WIDTH-2:MAGW])
            return '1;
        else
            return s[MAGW-1:FRAC];
    endfunction

    logic en;
    logic dout_valid_reg;
    logic v0_reg, v1_reg, v2_reg, v3_reg;

    assign en        = !dout_valid_reg || dout_ready;
    assign din_ready = en;

    logic signed [INT_WIDTH:0] dcb_c, dcr_c;
    fp_t y_fp, dcb_fp, dcr_fp;

    assign dcb_c  = $signed({1'b0, Cb}) - $signed({2'b01, {(INT_WIDTH-1){1'b0}}});
    assign dcr_c  = $signed({1'b0, Cr}) - $signed({2'b01, {(INT_WIDTH-1){1'b0}}});
    assign y_fp   = {{(FP_WIDTH-MAGW){1'b0}}, Y, {FRAC{1'b0}}};
    assign dcb_fp = {{(FP_WIDTH-INT_WIDTH-1-FRAC){dcb_c[INT_WIDTH]}}, dcb_c, {FRAC{1'b0}}};
    assign dcr_fp = {{(FP_WIDTH-INT_WIDTH-1-FRAC){dcr_c[INT_WIDTH]}}, dcr_c, {FRAC{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_reg         <= 1'b0;
            v1_reg         <= 1'b0;
            v2_reg         <= 1'b0;
            v3_reg         <= 1'b0;
            dout_valid_reg <= 1'b0;
        end else if (en) begin
            v0_reg         <= din_valid;
            v1_reg         <= v0_reg;
            v2_reg         <= v1_reg;
            v3_reg         <= v2_reg;
            dout_valid_reg <= v3_reg;
        end
    end

    fp_t y0_reg, cb0_reg, cr0_reg;
    fp_t y1_reg;
    fp_t cb_sh_reg [NSH];
    fp_t cr_sh_reg [NSH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_reg  <= '0;
            cb0_reg <= '0;
            cr0_reg <= '0;
            y1_reg  <= '0;
        end else if (en) begin
            y0_reg  <= y_fp;
            cb0_reg <= dcb_fp;
            cr0_reg <= dcr_fp;
            y1_reg  <= y0_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NSH; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cb_sh_reg[gi] <= '0;
                    cr_sh_reg[gi] <= '0;
                end else if (en) begin
                    cb_sh_reg[gi] <= cb0_reg >>> CB_SH[gi];
                    cr_sh_reg[gi] <= cr0_reg >>> CR_SH[gi];
                end
            end
        end
    endgenerate

    fp_t y2_reg, r_sum_reg, b_sum_reg, g_chroma_reg;
    fp_t r_rnd_reg, g_rnd_reg, b_rnd_reg;

    // cb_sh_reg index -> shift: 0,1,2,4,5,6; cr_sh_reg index == shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y2_reg       <= '0;
            r_sum_reg    <= '0;
            b_sum_reg    <= '0;
            g_chroma_reg <= '0;
            r_rnd_reg    <= '0;
            g_rnd_reg    <= '0;
            b_rnd_reg    <= '0;
        end else if (en) begin
            y2_reg       <= y1_reg;
            r_sum_reg    <= y1_reg + cr_sh_reg[0] + cr_sh_reg[2] + cr_sh_reg[3] + cr_sh_reg[5];
            b_sum_reg    <= y1_reg + cb_sh_reg[0] + cb_sh_reg[1] + cb_sh_reg[2] + cb_sh_reg[5];
            g_chroma_reg <= cb_sh_reg[2] + cb_sh_reg[3] + cb_sh_reg[4]
                          + cr_sh_reg[1] + cr_sh_reg[3] + cr_sh_reg[4] + cr_sh_reg[5];
            r_rnd_reg    <= r_sum_reg + fp_t'(128);
            g_rnd_reg    <= y2_reg - g_chroma_reg + fp_t'(128);
            b_rnd_reg    <= b_sum_reg + fp_t'(128);
        end
    end

    logic [INT_WIDTH-1:0] r_reg, g_reg, b_reg;

    // Output pixel only changes on a real pixel, so it holds through bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
            g_reg <= '0;
            b_reg <= '0;
        end else if (en && v3_reg) begin
            r_reg <= sat_pixel(r_rnd_reg);
            g_reg <= sat_pixel(g_rnd_reg);
            b_reg <= sat_pixel(b_rnd_reg);
        end
    end

    assign R          = r_reg;
    assign G          = g_reg;
    assign B          = b_reg;
    assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: directed pixels, backpressure, bubbles,
// random traffic against an arithmetic colour model, and reset mid-stream.
module tb_ycbcr2rgb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Y, Cb, Cr, R, G, B;
    logic       din_valid, din_ready, dout_valid, dout_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]  py [64];
    logic [7:0]  pcb [64];
    logic [7:0]  pcr [64];
    logic        dv_log [512];
    logic        dr_log [512];
    int          log_len;
    int          n_out;
    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    ycbcr2rgb #(.INT_WIDTH(8), .FP_WIDTH(18)) dut (
        .clk(clk), .rst_n(rst_n),
        .Y(Y), .Cb(Cb), .Cr(Cr),
        .din_valid(din_valid), .din_ready(din_ready),
        .R(R), .G(G), .B(B),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    function automatic logic [7:0] sat(input int v);
        int s;
        s = v + 128;
        if (s < 0) return 8'd0;
        if (s >= 65536) return 8'd255;
        return 8'(s / 256);
    endfunction

    // Coefficients scaled by 256: 1.40625, 0.34375, 0.71875, 1.765625.
    function automatic logic [23:0] model(input int y, input int cb, input int cr);
        int dcb, dcr;
        dcb = cb - 128;
        dcr = cr - 128;
        return {sat(y*256 + dcr*360), sat(y*256 - dcb*88 - dcr*184), sat(y*256 + dcb*452)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        Y = 8'd0; Cb = 8'd0; Cr = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dout_valid got %b want 0", dout_valid);
        end
        checks++;
        if ({R, G, B} !== 24'd0) begin
            errors++; $display("FAIL reset_rgb got %h want 000000", {R, G, B});
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL reset_din_ready got %b want 1", din_ready);
        end
        rst_n = 1'b1;
    endtask

    // One isolated pixel: exact 4-edge latency and converted value.
    task automatic test_pixel(input string name, input logic [7:0] y, input logic [7:0] cb,
                              input logic [7:0] cr);
        logic [23:0] e;
        e = model(y, cb, cr);
        @(posedge clk); #1;
        din_valid = 1'b1; dout_ready = 1'b1; Y = y; Cb = cb; Cr = cr;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL %s_accept din_ready got %b want 1", name, din_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            din_valid = 1'b0; Y = 8'($urandom); Cb = 8'($urandom); Cr = 8'($urandom);
            @(negedge clk);
            checks++;
            if (dout_valid !== (k == 5)) begin
                errors++;
                $display("FAIL %s_latency edge+%0d dout_valid got %b want %b", name, k - 1,
                         dout_valid, (k == 5));
            end
        end
        checks++;
        if ({R, G, B} !== e) begin
            errors++;
            $display("FAIL %s_rgb got %0d/%0d/%0d want %0d/%0d/%0d", name, R, G, B,
                     e[23:16], e[15:8], e[7:0]);
        end
        $display("pixel %s Y/Cb/Cr %0d/%0d/%0d -> R/G/B %0d/%0d/%0d", name, y, cb, cr, R, G, B);
    endtask

    // mode 0: backpressure window, 1: alternating bubbles, 2: random traffic.
    task automatic run_stream(input int mode, input int n_pix, input int max_cycles);
        int          idx = 0;
        int          c = 0;
        logic        held = 1'b0;
        logic        have_last = 1'b0;
        logic [23:0] held_rgb = '0;
        logic [23:0] last_rgb = '0;
        logic [23:0] got, e;
        exp_q.delete();
        n_out = 0;
        din_valid = 1'b0; dout_ready = 1'b1;
        repeat (6) @(posedge clk);
        while (!(idx >= n_pix && exp_q.size() == 0)) begin
            if (c >= max_cycles) begin
                checks++; errors++;
                $display("FAIL stream_timeout mode %0d pending %0d want 0", mode, exp_q.size());
                break;
            end
            @(posedge clk); #1;
            case (mode)
                0: begin
                    din_valid  = (idx < n_pix);
                    dout_ready = !(c >= 5 && c <= 8);
                end
                1: begin
                    din_valid  = (idx < n_pix) && (c % 2 == 0);
                    dout_ready = 1'b1;
                end
                default: begin
                    din_valid  = (idx < n_pix) && ($urandom_range(0, 9) < 7);
                    dout_ready = ($urandom_range(0, 9) < 7);
                end
            endcase
            if (din_valid) begin
                Y = py[idx]; Cb = pcb[idx]; Cr = pcr[idx];
            end else begin
                Y = 8'($urandom); Cb = 8'($urandom); Cr = 8'($urandom);
            end
            @(negedge clk);
            dv_log[c] = dout_valid;
            dr_log[c] = din_ready;
            got = {R, G, B};
            checks++;
            if (din_ready !== !(dout_valid && !dout_ready)) begin
                errors++;
                $display("FAIL din_ready cycle %0d got %b want %b", c, din_ready,
                         !(dout_valid && !dout_ready));
            end
            if (held) begin
                checks++;
                if (dout_valid !== 1'b1 || got !== held_rgb) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got %b/%h want 1/%h", c, dout_valid,
                             got, held_rgb);
                end
            end else if (dout_valid === 1'b0 && have_last) begin
                checks++;
                if (got !== last_rgb) begin
                    errors++;
                    $display("FAIL gap_hold cycle %0d got %h want %h", c, got, last_rgb);
                end
            end
            if (dout_valid === 1'b1 && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output cycle %0d got %h want none", c, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL stream_rgb out %0d got %h want %h", n_out, got, e);
                    end
                    $display("out %0d cycle %0d R/G/B %0d/%0d/%0d", n_out, c, R, G, B);
                end
                n_out++;
            end
            if (dout_valid === 1'b1) begin
                have_last = 1'b1;
                last_rgb  = got;
            end
            held     = (dout_valid === 1'b1) && !dout_ready;
            held_rgb = got;
            if (din_valid && din_ready === 1'b1) begin
                exp_q.push_back(model(py[idx], pcb[idx], pcr[idx]));
                idx++;
            end
            c++;
        end
        log_len = c;
        din_valid = 1'b0; dout_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            py[i] = 8'(i * 23 + 7); pcb[i] = 8'($urandom); pcr[i] = 8'($urandom);
        end
        run_stream(0, 10, 200);
        checks++;
        if (n_out !== 10) begin
            errors++; $display("FAIL bp_count got %0d want 10", n_out);
        end
        for (int c = 0; c < 13 && c < log_len; c++) begin
            checks++;
            if (dr_log[c] !== !(c >= 5 && c <= 8)) begin
                errors++;
                $display("FAIL bp_din_ready cycle %0d got %b want %b", c, dr_log[c],
                         !(c >= 5 && c <= 8));
            end
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 3; i++) begin
            py[i] = 8'($urandom); pcb[i] = 8'($urandom); pcr[i] = 8'($urandom);
        end
        run_stream(1, 3, 100);
        checks++;
        if (log_len < 10) begin
            errors++; $display("FAIL bubble_len got %0d want 10", log_len);
        end
        for (int c = 0; c < 10 && c < log_len; c++) begin
            checks++;
            if (dv_log[c] !== (c >= 5 && (c - 5) % 2 == 0)) begin
                errors++;
                $display("FAIL bubble_valid cycle %0d got %b want %b", c, dv_log[c],
                         (c >= 5 && (c - 5) % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            py[i] = 8'($urandom); pcb[i] = 8'($urandom); pcr[i] = 8'($urandom);
        end
        run_stream(2, 40, 2000);
        checks++;
        if (n_out !== 40) begin
            errors++; $display("FAIL random_count got %0d want 40", n_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            din_valid = 1'b1; dout_ready = 1'b1;
            Y = 8'($urandom); Cb = 8'($urandom); Cr = 8'($urandom);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || {R, G, B} !== 24'd0) begin
            errors++;
            $display("FAIL midreset_clear got %b/%h want 0/000000", dout_valid, {R, G, B});
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_din_ready got %b want 1", din_ready);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_hold got %b want 0", dout_valid);
        end
        rst_n = 1'b1;
        test_pixel("after_reset", 8'd200, 8'd90, 8'd170);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pixel("grey", 8'd128, 8'd128, 8'd128);
        test_pixel("mixed", 8'd100, 8'd160, 8'd96);
        test_pixel("sat_high", 8'd255, 8'd128, 8'd255);
        test_pixel("sat_low", 8'd0, 8'd128, 8'd0);
        test_backpressure();
        test_bubbles();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
